// File: rtl/paralelo_serial_pkg.sv
// Shared constants for the paralelo_serial transmitter: comma byte, FSM encodings,
// default sync length and the comma-counter update rule.
package paralelo_serial_pkg;

    localparam logic [7:0] IDLE_BYTE_DEF  = 8'hBC;
    localparam int         SYNC_BYTES_DEF = 4;

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Comma counter step: saturating increment on idle bytes, clear on anything else.
    function automatic logic [2:0] bc_count_next(
        input logic [2:0] cnt,
        input logic [7:0] loaded,
        input logic [7:0] idle
    );
        logic [2:0] nxt;
        if (loaded == idle) begin
            if (cnt == 3'd7) begin
                nxt = 3'd7;
            end else begin
                nxt = cnt + 3'd1;
            end
        end else begin
            nxt = 3'd0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/paralelo_serial_tx_shift_reg8.sv
// 8-bit load/shift register with its bit counter; emits the serial bit MSB-first
// and flags the edge on which the next byte must be presented.
module tx_shift_reg8 (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] load_data,
    output logic       load,
    output logic       data_out
);

    logic [7:0] shift_r;
    logic [2:0] bit_cnt_r;

    // Load a fresh byte when the counter sits at 7, otherwise shift left zero-filled.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            shift_r   <= 8'h00;
            bit_cnt_r <= 3'd7;
        end else if (bit_cnt_r == 3'd7) begin
            shift_r   <= load_data;
            bit_cnt_r <= 3'd0;
        end else begin
            shift_r   <= {shift_r[6:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + 3'd1;
        end
    end

    assign load     = (bit_cnt_r == 3'd7);
    assign data_out = shift_r[7];

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial link transmitter: sends SYNC_BYTES comma bytes after reset,
// then data or comma per byte slot. Optional comma counter: PARALELO_SERIAL_BC_COUNT_EN.
module paralelo_serial
    import paralelo_serial_pkg::*;
#(
    parameter int         SYNC_BYTES = SYNC_BYTES_DEF,
    parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEF
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       data_out,
    output logic       active
`ifdef PARALELO_SERIAL_BC_COUNT_EN
    ,
    output logic [2:0] BC_counter
`endif
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

    logic [0:0] state_r;
    logic [3:0] sync_cnt_r;
    logic       load_s;
    logic [7:0] byte_sel_s;

    // Byte chosen for the next slot; data only once the link is running.
    always_comb begin
        byte_sel_s = IDLE_BYTE;
        if ((state_r == ST_RUN) && valid_in) begin
            byte_sel_s = data_in;
        end else begin
            byte_sel_s = IDLE_BYTE;
        end
    end

    // Sync-phase FSM: count comma bytes, enter RUN on the last one; RUN holds until reset.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state_r    <= ST_SYNC;
            sync_cnt_r <= 4'd0;
        end else if (load_s && (state_r == ST_SYNC)) begin
            sync_cnt_r <= sync_cnt_r + 4'd1;
            if (sync_cnt_r == SYNC_LAST) begin
                state_r <= ST_RUN;
            end
        end
    end

    tx_shift_reg8 u_shift (
        .clk       (clk_32f),
        .reset_L   (reset_L),
        .load_data (byte_sel_s),
        .load      (load_s),
        .data_out  (data_out)
    );

    assign active = (state_r == ST_RUN);
    assign ready  = (state_r == ST_RUN) && load_s;

`ifdef PARALELO_SERIAL_BC_COUNT_EN
    // Mirror of the receiver's comma counter, updated per loaded byte.
    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            BC_counter <= 3'd0;
        end else if (load_s) begin
            BC_counter <= bc_count_next(BC_counter, byte_sel_s, IDLE_BYTE);
        end
    end
`endif

endmodule
